// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared constants and types for the ram_arbiter slice.
// Build option: RAM_ARB_INIT_EN enables the post-reset RAM clear.
package ram_arb_pkg;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rsp_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter, one-hot grant.
// Build option: none (RAM_ARB_INIT_EN is handled by the top).
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);
    import ram_arb_pkg::*;

    req_id_t r_last;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid == 2'b11) begin
                grant = r_last ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
    end

    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (grant != 2'b00) begin
            r_last <= grant[1];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin front end for a 1-port RAM.
// Build option: RAM_ARB_INIT_EN clears the RAM after every reset.
module ram_arbiter #(
    parameter int AW = ram_arb_pkg::AW,
    parameter int DW = ram_arb_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          r0_req_valid,
    output logic          r0_req_ready,
    input  logic          r0_req_we,
    input  logic [AW-1:0] r0_req_addr,
    input  logic [DW-1:0] r0_req_wdata,
    output logic          r0_rsp_valid,
    output logic [DW-1:0] r0_rsp_rdata,
    input  logic          r1_req_valid,
    output logic          r1_req_ready,
    input  logic          r1_req_we,
    input  logic [AW-1:0] r1_req_addr,
    input  logic [DW-1:0] r1_req_wdata,
    output logic          r1_rsp_valid,
    output logic [DW-1:0] r1_rsp_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          busy
);
    import ram_arb_pkg::*;

    localparam int DEPTH = 2 ** AW;

    state_t        r_state;
    state_t        w_state_nxt;
    rsp_tag_t      r_tag1;
    rsp_tag_t      r_tag2;
    rsp_tag_t      w_tag_nxt;
    logic          r_ram_we;
    logic          w_ram_we_nxt;
    logic [AW-1:0] r_ram_addr;
    logic [AW-1:0] w_ram_addr_nxt;
    logic [DW-1:0] r_ram_din;
    logic [DW-1:0] w_ram_din_nxt;
    logic [1:0]    w_valid;
    logic [1:0]    w_grant;
    logic          w_enable;
    logic          w_hs;
    req_id_t       w_sel;
    logic          w_cmd_we;
    logic [AW-1:0] w_cmd_addr;
    logic [DW-1:0] w_cmd_wdata;

`ifdef RAM_ARB_INIT_EN
    localparam state_t RST_STATE = INIT;
    logic [AW:0]   r_cnt;
    logic [AW:0]   w_cnt_nxt;
`else
    localparam state_t RST_STATE = RUN;
`endif

    // Gating with rst_n keeps ready low while reset is held.
    assign w_valid  = {r1_req_valid, r0_req_valid};
    assign w_enable = (r_state == RUN) && rst_n;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (w_valid),
        .enable (w_enable),
        .grant  (w_grant)
    );

    assign r0_req_ready = w_grant[0];
    assign r1_req_ready = w_grant[1];
    assign w_hs         = |w_grant;
    assign w_sel        = w_grant[1];
    assign w_cmd_we     = w_sel ? r1_req_we    : r0_req_we;
    assign w_cmd_addr   = w_sel ? r1_req_addr  : r0_req_addr;
    assign w_cmd_wdata  = w_sel ? r1_req_wdata : r0_req_wdata;

    assign w_tag_nxt.valid = w_hs && !w_cmd_we;
    assign w_tag_nxt.id    = w_sel;

    always_comb begin
        w_state_nxt    = r_state;
        w_ram_we_nxt   = 1'b0;
        w_ram_addr_nxt = r_ram_addr;
        w_ram_din_nxt  = r_ram_din;
`ifdef RAM_ARB_INIT_EN
        w_cnt_nxt      = r_cnt;
`endif
        case (r_state)
            INIT: begin
`ifdef RAM_ARB_INIT_EN
                // Wide counter: stop on DEPTH, not on address wrap.
                if (r_cnt == (AW+1)'(DEPTH)) begin
                    w_state_nxt = RUN;
                end else begin
                    w_ram_we_nxt   = 1'b1;
                    w_ram_addr_nxt = r_cnt[AW-1:0];
                    w_ram_din_nxt  = '0;
                    w_cnt_nxt      = r_cnt + 1'b1;
                end
`endif
            end
            RUN: begin
                if (w_hs) begin
                    w_ram_we_nxt   = w_cmd_we;
                    w_ram_addr_nxt = w_cmd_addr;
                    w_ram_din_nxt  = w_cmd_we ? w_cmd_wdata : '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RST_STATE;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_tag1     <= '0;
            r_tag2     <= '0;
`ifdef RAM_ARB_INIT_EN
            r_cnt      <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_ram_we   <= w_ram_we_nxt;
            r_ram_addr <= w_ram_addr_nxt;
            r_ram_din  <= w_ram_din_nxt;
            r_tag1     <= w_tag_nxt;
            r_tag2     <= r_tag1;
`ifdef RAM_ARB_INIT_EN
            r_cnt      <= w_cnt_nxt;
`endif
        end
    end

    assign ram_we   = r_ram_we;
    assign ram_addr = r_ram_addr;
    assign ram_din  = r_ram_din;

    assign r0_rsp_valid = r_tag2.valid && (r_tag2.id == 1'b0);
    assign r1_rsp_valid = r_tag2.valid && (r_tag2.id == 1'b1);
    assign r0_rsp_rdata = r0_rsp_valid ? ram_dout : '0;
    assign r1_rsp_rdata = r1_rsp_valid ? ram_dout : '0;

`ifdef RAM_ARB_INIT_EN
    assign busy = (r_state == INIT);
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized and directed checks of ram_arbiter
// against a cycle-keyed expectation model and a behavioural RAM.
module tb_ram_arbiter;

    localparam int NC = 4096;
`ifdef RAM_ARB_INIT_EN
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       r0_req_valid = 1'b0;
    logic       r0_req_ready;
    logic       r0_req_we = 1'b0;
    logic [2:0] r0_req_addr = '0;
    logic [7:0] r0_req_wdata = '0;
    logic       r0_rsp_valid;
    logic [7:0] r0_rsp_rdata;
    logic       r1_req_valid = 1'b0;
    logic       r1_req_ready;
    logic       r1_req_we = 1'b0;
    logic [2:0] r1_req_addr = '0;
    logic [7:0] r1_req_wdata = '0;
    logic       r1_rsp_valid;
    logic [7:0] r1_rsp_rdata;
    logic       ram_we;
    logic [2:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic       busy;

    logic [7:0] ram_mem [8];

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    logic       cmd_v  [NC];
    logic       cmd_we [NC];
    logic [2:0] cmd_a  [NC];
    logic [7:0] cmd_d  [NC];
    logic       rsp_v  [NC];
    logic       rsp_id [NC];
    logic       rsp_k  [NC];
    logic [7:0] rsp_d  [NC];
    logic [7:0] mem    [8];
    logic       known  [8];
    logic       last_g;
    logic [2:0] cur_a;
    logic [7:0] cur_d;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        else        ram_dout <= ram_mem[ram_addr];
    end

    ram_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .r0_req_valid (r0_req_valid),
        .r0_req_ready (r0_req_ready),
        .r0_req_we    (r0_req_we),
        .r0_req_addr  (r0_req_addr),
        .r0_req_wdata (r0_req_wdata),
        .r0_rsp_valid (r0_rsp_valid),
        .r0_rsp_rdata (r0_rsp_rdata),
        .r1_req_valid (r1_req_valid),
        .r1_req_ready (r1_req_ready),
        .r1_req_we    (r1_req_we),
        .r1_req_addr  (r1_req_addr),
        .r1_req_wdata (r1_req_wdata),
        .r1_rsp_valid (r1_rsp_valid),
        .r1_rsp_rdata (r1_rsp_rdata),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout),
        .busy         (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic flush();
        for (int i = 0; i < NC; i++) begin
            cmd_v[i] = 1'b0; cmd_we[i] = 1'b0;
            cmd_a[i] = '0;   cmd_d[i]  = '0;
            rsp_v[i] = 1'b0; rsp_id[i] = 1'b0;
            rsp_k[i] = 1'b0; rsp_d[i]  = '0;
        end
        last_g = 1'b1;
        cur_a  = '0;
        cur_d  = '0;
    endtask

    task automatic check_cycle(input logic [1:0] g);
        logic ev;
        chk("r0_ready", r0_req_ready, g[0]);
        chk("r1_ready", r1_req_ready, g[1]);
        chk("busy", busy, 0);
        ev = cmd_v[cyc];
        if (ev) begin
            cur_a = cmd_a[cyc];
            cur_d = cmd_d[cyc];
        end
        chk("ram_we", ram_we, ev && cmd_we[cyc]);
        chk("ram_addr", ram_addr, cur_a);
        chk("ram_din", ram_din, cur_d);
        chk("r0_rsp_valid", r0_rsp_valid, rsp_v[cyc] && !rsp_id[cyc]);
        chk("r1_rsp_valid", r1_rsp_valid, rsp_v[cyc] && rsp_id[cyc]);
        if (!(rsp_v[cyc] && !rsp_id[cyc])) chk("r0_rdata_idle", r0_rsp_rdata, 0);
        else if (rsp_k[cyc]) chk("r0_rdata", r0_rsp_rdata, rsp_d[cyc]);
        if (!(rsp_v[cyc] && rsp_id[cyc])) chk("r1_rdata_idle", r1_rsp_rdata, 0);
        else if (rsp_k[cyc]) chk("r1_rdata", r1_rsp_rdata, rsp_d[cyc]);
    endtask

    // One clock: drive after the edge, check on the falling edge.
    task automatic step(input logic v0, input logic w0,
                        input logic [2:0] a0, input logic [7:0] d0,
                        input logic v1, input logic w1,
                        input logic [2:0] a1, input logic [7:0] d1);
        logic [1:0] g;
        logic       id, cw;
        logic [2:0] ca;
        logic [7:0] cd;
        @(posedge clk);
        #1;
        cyc++;
        r0_req_valid = v0; r0_req_we = w0; r0_req_addr = a0; r0_req_wdata = d0;
        r1_req_valid = v1; r1_req_we = w1; r1_req_addr = a1; r1_req_wdata = d1;
        if (v0 && v1) g = last_g ? 2'b01 : 2'b10;
        else          g = {v1, v0};
        @(negedge clk);
        check_cycle(g);
        if (g != 2'b00) begin
            id = g[1];
            cw = id ? w1 : w0;
            ca = id ? a1 : a0;
            cd = id ? d1 : d0;
            last_g = id;
            cmd_v[cyc+1]  = 1'b1;
            cmd_we[cyc+1] = cw;
            cmd_a[cyc+1]  = ca;
            cmd_d[cyc+1]  = cw ? cd : 8'h00;
            if (cw) begin
                mem[ca]   = cd;
                known[ca] = 1'b1;
            end else begin
                rsp_v[cyc+2]  = 1'b1;
                rsp_id[cyc+2] = id;
                rsp_d[cyc+2]  = mem[ca];
                rsp_k[cyc+2]  = known[ca];
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ram_we"}, ram_we, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_ram_din"}, ram_din, 0);
        chk({tag, "_r0_valid"}, r0_rsp_valid, 0);
        chk({tag, "_r1_valid"}, r1_rsp_valid, 0);
        chk({tag, "_r0_rdata"}, r0_rsp_rdata, 0);
        chk({tag, "_r1_rdata"}, r1_rsp_rdata, 0);
        chk({tag, "_r0_ready"}, r0_req_ready, 0);
        chk({tag, "_r1_ready"}, r1_req_ready, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        r0_req_valid = 1'b1; r0_req_we = 1'b0;
        r1_req_valid = 1'b1; r1_req_we = 1'b0;
        #1;
        chk_zero_outputs("rst");
        chk("rst_busy", busy, BUSY_RST);
        flush();
        repeat (2) @(negedge clk);
        chk_zero_outputs("rst_hold");
        rst_n = 1'b1;
        r0_req_valid = 1'b0;
        r1_req_valid = 1'b0;
`ifdef RAM_ARB_INIT_EN
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            r0_req_valid = 1'b1;
            r1_req_valid = 1'b1;
            @(negedge clk);
            chk("init_busy", busy, 1);
            chk("init_we", ram_we, 1);
            chk("init_addr", ram_addr, i);
            chk("init_din", ram_din, 0);
            chk("init_r0_ready", r0_req_ready, 0);
            chk("init_r1_ready", r1_req_ready, 0);
            chk("init_rsp", r0_rsp_valid | r1_rsp_valid, 0);
        end
        r0_req_valid = 1'b0;
        r1_req_valid = 1'b0;
        cur_a = 3'd7;
        cur_d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            mem[i]   = 8'h00;
            known[i] = 1'b1;
        end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem[i]   = 8'h00;
            known[i] = 1'b0;
        end
        #3;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            if (i < 6) step(1, 0, 3'(i), 0, 1, 0, 3'(i + 1), 0);
            else       idle();
            if (i < 6) chk("cont_r0_grant", r0_req_ready, (i % 2) == 0);
            if (i >= 2) begin
                chk("cont_r0_rsp", r0_rsp_valid, (i % 2) == 0);
                chk("cont_r1_rsp", r1_rsp_valid, (i % 2) == 1);
            end
        end

        step(1, 1, 3'd3, 8'hA5, 0, 0, 0, 0);
        step(1, 0, 3'd3, 8'h00, 0, 0, 0, 0);
        idle();
        idle();
        chk("wr_rd_r0_valid", r0_rsp_valid, 1);
        chk("wr_rd_r0_data", r0_rsp_rdata, 8'hA5);
        chk("wr_rd_r1_valid", r1_rsp_valid, 0);

        step(1, 1, 3'd5, 8'h3C, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 3'd5, 8'h00);
        idle();
        idle();
        chk("raw_r1_valid", r1_rsp_valid, 1);
        chk("raw_r1_data", r1_rsp_rdata, 8'h3C);

        for (int i = 0; i < 4; i++) begin
            idle();
            chk("idle_we", ram_we, 0);
            chk("idle_addr", ram_addr, 3'd5);
            chk("idle_rsp", r0_rsp_valid | r1_rsp_valid, 0);
        end

        step(0, 0, 0, 0, 1, 0, 3'd2, 8'h00);
        @(posedge clk);
        #1;
        cyc++;
        r1_req_valid = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("midrst_no_rsp", r0_rsp_valid | r1_rsp_valid, 0);
        end

        for (int i = 0; i < 1200; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1),
                 3'($urandom), 8'($urandom),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 1),
                 3'($urandom), 8'($urandom));
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
